imm_gen: RTL and testbench

- Registered RV32I immediate generator in the decode stage.
- Takes a 32-bit instruction word and decodes its format from the opcode.
- Produces the sign- or zero-extended 32-bit immediate, a format code and an illegal-opcode flag, one clock after the instruction is presented.

---
 rtl/imm_gen.sv | 178 +++++++++++++++++
 tb/tb_imm_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - Registered RV32I immediate generator for the decode stage
//
// Decodes the instruction format from the opcode and registers the extended
// immediate, a format code and an illegal-opcode flag one clock after the
// instruction is presented.
//
// Optional feature macro: IMM_GEN_ZICSR_EN
//   defined   - SYSTEM opcodes produce CSR immediates (zimm as fmt Z, or the
//               zero-extended CSR address as fmt I)
//   undefined - SYSTEM opcodes produce imm=0, fmt=NONE, illegal=0
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   stall      in   1 = every output register holds
//   inst_valid in   inst carries a valid instruction this cycle
//   inst       in   32-bit instruction word
//   imm        out  extended immediate (registered)
//   imm_valid  out  imm/fmt/illegal belong to a valid instruction
//   fmt        out  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 reserved
//   illegal    out  unrecognised opcode or inst[1:0] != 2'b11

module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic            imm_valid,
    output logic [2:0]      fmt,
    output logic            illegal
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("imm_gen: only XLEN=32 is supported");
    end

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        s;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign s      = inst[31];

    logic [31:0] dec_imm;
    logic [2:0]  dec_fmt;
    logic        dec_illegal;

    always_comb begin
        dec_imm     = 32'd0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        // Compressed/non-32-bit encodings are never legal here, whatever the opcode.
        if (inst[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD, OP_JALR: begin
                    dec_imm = {{20{s}}, inst[31:20]};
                    dec_fmt = FMT_I;
                end
                OP_OP_IMM: begin
                    dec_fmt = FMT_I;
                    // Shifts carry a 5-bit shamt; funct7 (e.g. SRAI's bit 30) must not leak in.
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec_imm = {27'd0, inst[24:20]};
                    end else begin
                        dec_imm = {{20{s}}, inst[31:20]};
                    end
                end
                OP_STORE: begin
                    dec_imm = {{20{s}}, inst[31:25], inst[11:7]};
                    dec_fmt = FMT_S;
                end
                OP_BRANCH: begin
                    dec_imm = {{19{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                    dec_fmt = FMT_B;
                end
                OP_LUI, OP_AUIPC: begin
                    dec_imm = {inst[31:12], 12'd0};
                    dec_fmt = FMT_U;
                end
                OP_JAL: begin
                    dec_imm = {{11{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                    dec_fmt = FMT_J;
                end
                OP_OP, OP_MISC_MEM: begin
                    dec_imm = 32'd0;
                end
                OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                    // funct3 1xx except 100 are the immediate CSR forms (zimm in rs1 field).
                    if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
                        dec_imm = {27'd0, inst[19:15]};
                        dec_fmt = FMT_Z;
                    end else begin
                        dec_imm = {20'd0, inst[31:20]};
                        dec_fmt = FMT_I;
                    end
`else
                    dec_imm = 32'd0;
`endif
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    logic [31:0] imm_q, imm_d;
    logic [2:0]  fmt_q, fmt_d;
    logic        illegal_q, illegal_d;
    logic        valid_q, valid_d;

    // Payload registers only load on a valid instruction so they do not
    // toggle on bubbles; imm_valid alone tracks the bubble.
    always_comb begin
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;
        if (!stall) begin
            valid_d = inst_valid;
            if (inst_valid) begin
                imm_d     = dec_imm;
                fmt_d     = dec_fmt;
                illegal_d = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q     <= 32'd0;
            fmt_q     <= FMT_NONE;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end

    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign illegal   = illegal_q;
    assign imm_valid = valid_q;

endmodule

// File: tb/tb_imm_gen.sv
// tb/tb_imm_gen.sv - Directed self-checking bench for imm_gen
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        imm_valid;
    logic [2:0]  fmt;
    logic        illegal;

    int errors;
    int checks;

    imm_gen #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .inst_valid (inst_valid),
        .inst       (inst),
        .imm        (imm),
        .imm_valid  (imm_valid),
        .fmt        (fmt),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction and sample 1 ns after the capturing edge.
    task automatic drive(input logic [31:0] i, input logic v, input logic st);
        inst       = i;
        inst_valid = v;
        stall      = st;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        inst_valid = 1'b0;
        inst = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({imm, imm_valid, fmt, illegal} !== 37'd0) begin
            errors++;
            $display("FAIL reset_init: imm=%h v=%b fmt=%0d ill=%b required all zero", imm, imm_valid, fmt, illegal);
        end
        rst_n = 1'b1;
        // Load something nonzero, then drop reset between edges.
        drive(32'hFFF00093, 1'b1, 1'b0);
        checks++;
        if (imm !== 32'hFFFFFFFF || imm_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: imm=%h v=%b required ffffffff 1", imm, imm_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imm, imm_valid, fmt, illegal} !== 37'd0) begin
            errors++;
            $display("FAIL reset_async: imm=%h v=%b fmt=%0d ill=%b required all zero", imm, imm_valid, fmt, illegal);
        end
        inst_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        inst = 32'h00500093;
        inst_valid = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (imm_valid !== 1'b0 || imm !== 32'd0) begin
            errors++;
            $display("FAIL latency_before_edge: v=%b imm=%h required 0 00000000", imm_valid, imm);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imm_valid !== 1'b1 || imm !== 32'h5 || fmt !== 3'd1) begin
            errors++;
            $display("FAIL latency_after_edge: v=%b imm=%h fmt=%0d required 1 00000005 1", imm_valid, imm, fmt);
        end
    endtask

    task automatic test_decode();
        logic [31:0] vi [11];
        logic [31:0] ve [11];
        logic [2:0]  vf [11];
        logic        vl [11];
        vi[0]  = 32'h00500093; ve[0]  = 32'h00000005; vf[0]  = 3'd1; vl[0]  = 1'b0;
        vi[1]  = 32'hFFF00093; ve[1]  = 32'hFFFFFFFF; vf[1]  = 3'd1; vl[1]  = 1'b0;
        vi[2]  = 32'h00102223; ve[2]  = 32'h00000004; vf[2]  = 3'd2; vl[2]  = 1'b0;
        vi[3]  = 32'h00000463; ve[3]  = 32'h00000008; vf[3]  = 3'd3; vl[3]  = 1'b0;
        vi[4]  = 32'hFE000EE3; ve[4]  = 32'hFFFFFFFC; vf[4]  = 3'd3; vl[4]  = 1'b0;
        vi[5]  = 32'h123450B7; ve[5]  = 32'h12345000; vf[5]  = 3'd4; vl[5]  = 1'b0;
        vi[6]  = 32'h008000EF; ve[6]  = 32'h00000008; vf[6]  = 3'd5; vl[6]  = 1'b0;
        vi[7]  = 32'h40505093; ve[7]  = 32'h00000005; vf[7]  = 3'd1; vl[7]  = 1'b0;
        vi[8]  = 32'h0000007F; ve[8]  = 32'h00000000; vf[8]  = 3'd0; vl[8]  = 1'b1;
        vi[9]  = 32'h00000000; ve[9]  = 32'h00000000; vf[9]  = 3'd0; vl[9]  = 1'b1;
        vi[10] = 32'h002081B3; ve[10] = 32'h00000000; vf[10] = 3'd0; vl[10] = 1'b0;
        for (int k = 0; k < 11; k++) begin
            drive(vi[k], 1'b1, 1'b0);
            checks++;
            if (imm !== ve[k] || fmt !== vf[k] || illegal !== vl[k] || imm_valid !== 1'b1) begin
                errors++;
                $display("FAIL decode_%h: imm=%h fmt=%0d ill=%b v=%b required %h %0d %b 1",
                         vi[k], imm, fmt, illegal, imm_valid, ve[k], vf[k], vl[k]);
            end
        end
    endtask

    task automatic test_system();
        logic [31:0] vi [2];
        logic [31:0] ve [2];
        logic [2:0]  vf [2];
        vi[0] = 32'h3401D0F3;
        vi[1] = 32'h34029073;
`ifdef IMM_GEN_ZICSR_EN
        ve[0] = 32'h00000003; vf[0] = 3'd6;
        ve[1] = 32'h00000340; vf[1] = 3'd1;
`else
        ve[0] = 32'h00000000; vf[0] = 3'd0;
        ve[1] = 32'h00000000; vf[1] = 3'd0;
`endif
        for (int k = 0; k < 2; k++) begin
            drive(vi[k], 1'b1, 1'b0);
            checks++;
            if (imm !== ve[k] || fmt !== vf[k] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL system_%h: imm=%h fmt=%0d ill=%b required %h %0d 0",
                         vi[k], imm, fmt, illegal, ve[k], vf[k]);
            end
        end
    endtask

    task automatic test_handshake();
        drive(32'h00500093, 1'b1, 1'b0);
        drive(32'hFFF00093, 1'b1, 1'b1);
        checks++;
        if (imm !== 32'h5 || imm_valid !== 1'b1 || fmt !== 3'd1) begin
            errors++;
            $display("FAIL stall_hold: imm=%h v=%b fmt=%0d required 00000005 1 1", imm, imm_valid, fmt);
        end
        drive(32'hFFF00093, 1'b0, 1'b1);
        checks++;
        if (imm_valid !== 1'b1 || imm !== 32'h5) begin
            errors++;
            $display("FAIL stall_hold_valid: v=%b imm=%h required 1 00000005", imm_valid, imm);
        end
        drive(32'hFFF00093, 1'b0, 1'b0);
        checks++;
        if (imm_valid !== 1'b0 || imm !== 32'h5 || fmt !== 3'd1) begin
            errors++;
            $display("FAIL bubble_hold: v=%b imm=%h fmt=%0d required 0 00000005 1", imm_valid, imm, fmt);
        end
        drive(32'h0000007F, 1'b1, 1'b0);
        drive(32'h00500093, 1'b0, 1'b0);
        checks++;
        if (imm_valid !== 1'b0 || illegal !== 1'b1 || imm !== 32'd0) begin
            errors++;
            $display("FAIL bubble_hold_illegal: v=%b ill=%b imm=%h required 0 1 00000000", imm_valid, illegal, imm);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h123450B7, 1'b1, 1'b0);
        drive(32'h008000EF, 1'b1, 1'b0);
        checks++;
        if (imm !== 32'h8 || fmt !== 3'd5 || imm_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: imm=%h fmt=%0d v=%b required 00000008 5 1", imm, fmt, imm_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_decode();
        test_system();
        test_handshake();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
